data_mem: RTL and testbench
===========================

# data_mem

Data-memory responder for the 8-bit core's data port. Accepts the core's registered address, write data and one-cycle write-enable strobe. Returns read data combinationally so the core can sample it in the cycle after it loads its address register. The address space is split into general-purpose RAM and a memory-mapped peripheral window holding a GPIO port and an 8-bit timer with compare flag and interrupt.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 8, data address width
- MEM_DATA_WIDTH, 8, data word width
- MMIO_BASE, 8'hF0, first peripheral address; RAM occupies 0 .. MMIO_BASE-1

Ports:
- clk  in  1  system clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- mem_addr  in  MEM_ADDR_WIDTH  address from the core
- mem_data_i  in  MEM_DATA_WIDTH  write data from the core
- mem_WE  in  1  write strobe; one cycle per write
- mem_data_o  out  MEM_DATA_WIDTH  read data, combinational from mem_addr
- gpio_i  in  8  external inputs, asynchronous
- gpio_o  out  8  GPIO output register
- irq_o  out  1  timer interrupt: match flag AND irq enable

## Operation
- The write commits on the rising edge that ends a cycle with mem_WE=1, using mem_addr/mem_data_i from that same cycle.
- RAM (addr < MMIO_BASE): not reset; read returns the last value written.
- Peripheral map (offset from MMIO_BASE):
  - +0 GPIO_OUT: read/write; drives gpio_o.
  - +1 GPIO_IN: read-only; gpio_i after a 2-flop synchronizer; writes are ignored.
  - +2 TMR_CNT: read/write; a write loads the counter.
  - +3 TMR_CMP: read/write compare value.
  - +4 TMR_CTRL:
    - bit0 EN
    - bits3:1 PSC: tick every 2^PSC cycles
    - bit6 IE
    - bit7 MF match flag
    - bits5:4 read 0
  - +5..+15: read 0x00; writes ignored.
- Prescaler: 8-bit free-running counter, active only while EN=1. A tick occurs when its low PSC bits are all ones. It is cleared when EN=0 and on any TMR_CTRL write.
- On each tick TMR_CNT increments, wrapping 0xFF->0x00. MF sets when the incremented value equals TMR_CMP.
- Writing TMR_CTRL with bit7=1 clears MF; bit7=0 leaves MF unchanged. Other bits load directly.
- Reset values: gpio_o=0x00, TMR_CNT=0x00, TMR_CMP=0xFF, TMR_CTRL=0x00, prescaler=0, synchronizer=0, irq_o=0.

## Timing
- Read latency is 0 cycles: mem_data_o is a function of mem_addr and current register/RAM state. Reads have no side effects.
- Write-then-read at the same address shows the new value starting the cycle after the write edge.
- GPIO_IN reflects a gpio_i change 2 edges later. gpio_o updates on the write edge.
- irq_o is registered logic only: it rises the cycle after the tick that sets MF and falls the cycle after the clearing write.
- Simultaneous events:
  - TMR_CNT write on a tick cycle: the write wins and no increment occurs.
  - MF set and clear on the same edge: set wins.
  - TMR_CMP write on a tick cycle: the compare uses the old TMR_CMP.
- Reset mid-write: arst_n low forces all peripheral registers to reset values immediately. A RAM write in that cycle is discarded.

## Structure
- Add to defines.v:
  - peripheral offsets GPIO_OUT/GPIO_IN/TMR_CNT/TMR_CMP/TMR_CTRL
  - TMR_CTRL bit positions EN/PSC/IE/MF
- data_mem contains the RAM array, address decode, read mux, GPIO registers and synchronizer.
- Sub-module mmio_timer holds prescaler, counter, compare, control and flag logic. Its interface is a write strobe, 3 register selects, write data, and read-back of the 3 registers plus irq.

## Test plan
- Reset, then write 0x5A to 0x10 and 0xA5 to 0xEF. Reading 0x10/0xEF returns 0x5A/0xA5 with mem_WE=0; reading 0xF7 returns 0x00.
- Write 0x3C to 0xF0 -> gpio_o=0x3C on the next cycle. Drive gpio_i=0x81 -> reading 0xF1 returns 0x81 exactly 2 edges later.
- TMR_CMP=0x03, TMR_CTRL=0x41 (EN, PSC=0, IE) -> TMR_CNT reads 1, 2, 3 on successive cycles. MF and irq_o are set after the 3rd tick. Writing 0x80|0x41 to TMR_CTRL clears irq_o the next cycle.
- TMR_CNT=0xFE, PSC=2, EN -> increments every 4 cycles, 0xFE->0xFF->0x00, wrapping without a flag (TMR_CMP=0x10).
- Write TMR_CNT=0x20 on the exact tick cycle -> reads 0x20, not 0x21. A clear-MF write coincident with a match edge leaves MF=1.
- Assert arst_n low mid-count with gpio_o=0xFF and MF=1 -> all peripheral reads and outputs return reset values immediately. A RAM write issued in that cycle is not retained.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: peripheral window offsets,
// TMR_CTRL bit positions and the address-region decode.
package data_mem_pkg;

  localparam int PERIPH_OFF_W = 4;

  localparam logic [PERIPH_OFF_W-1:0] OFF_GPIO_OUT = 4'h0;
  localparam logic [PERIPH_OFF_W-1:0] OFF_GPIO_IN  = 4'h1;
  localparam logic [PERIPH_OFF_W-1:0] OFF_TMR_CNT  = 4'h2;
  localparam logic [PERIPH_OFF_W-1:0] OFF_TMR_CMP  = 4'h3;
  localparam logic [PERIPH_OFF_W-1:0] OFF_TMR_CTRL = 4'h4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_PSC_LSB = 1;
  localparam int CTRL_PSC_MSB = 3;
  localparam int CTRL_IE      = 6;
  localparam int CTRL_MF      = 7;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_GPIO_OUT,
    RGN_GPIO_IN,
    RGN_TMR_CNT,
    RGN_TMR_CMP,
    RGN_TMR_CTRL,
    RGN_UNMAPPED
  } region_e;

  function automatic region_e decodeOffset(input logic [PERIPH_OFF_W-1:0] off);
    region_e rgn;
    case (off)
      OFF_GPIO_OUT: rgn = RGN_GPIO_OUT;
      OFF_GPIO_IN:  rgn = RGN_GPIO_IN;
      OFF_TMR_CNT:  rgn = RGN_TMR_CNT;
      OFF_TMR_CMP:  rgn = RGN_TMR_CMP;
      OFF_TMR_CTRL: rgn = RGN_TMR_CTRL;
      default:      rgn = RGN_UNMAPPED;
    endcase
    return rgn;
  endfunction

endpackage

// File: rtl/data_mem_mmio_timer.sv
// 8-bit timer with power-of-two prescaler, compare match flag and interrupt,
// exposed as three memory-mapped registers.
module mmio_timer
  import data_mem_pkg::*;
(
  input  logic       clk,
  input  logic       arst_n,
  input  logic       i_we,
  input  logic       i_selCnt,
  input  logic       i_selCmp,
  input  logic       i_selCtrl,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_cnt,
  output logic [7:0] o_cmp,
  output logic [7:0] o_ctrl,
  output logic       o_irq
);

  logic [7:0] r_prescale;
  logic [7:0] r_cnt;
  logic [7:0] r_cmp;
  logic       r_en;
  logic [2:0] r_psc;
  logic       r_ie;
  logic       r_mf;

  logic [7:0] w_pscMask;
  logic [7:0] w_cntInc;
  logic       w_tick;
  logic       w_cntWr;
  logic       w_cmpWr;
  logic       w_ctrlWr;
  logic       w_match;

  assign w_cntWr  = i_we && i_selCnt;
  assign w_cmpWr  = i_we && i_selCmp;
  assign w_ctrlWr = i_we && i_selCtrl;

  // A tick fires when the low PSC prescaler bits are all ones.
  assign w_pscMask = ~(8'hFF << r_psc);
  assign w_tick    = r_en && ((r_prescale & w_pscMask) == w_pscMask);
  assign w_cntInc  = r_cnt + 8'd1;

  // A counter load suppresses the increment, so it cannot raise a match either.
  assign w_match   = w_tick && !w_cntWr && (w_cntInc == r_cmp);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_prescale <= 8'h00;
      r_cnt      <= 8'h00;
      r_cmp      <= 8'hFF;
      r_en       <= 1'b0;
      r_psc      <= 3'd0;
      r_ie       <= 1'b0;
      r_mf       <= 1'b0;
    end else begin
      if (!r_en || w_ctrlWr) r_prescale <= 8'h00;
      else                   r_prescale <= r_prescale + 8'd1;

      if (w_cntWr)     r_cnt <= i_wdata;
      else if (w_tick) r_cnt <= w_cntInc;

      if (w_cmpWr) r_cmp <= i_wdata;

      if (w_ctrlWr) begin
        r_en  <= i_wdata[CTRL_EN];
        r_psc <= i_wdata[CTRL_PSC_MSB:CTRL_PSC_LSB];
        r_ie  <= i_wdata[CTRL_IE];
      end

      // Set has priority over a coincident write-one-to-clear.
      if (w_match)                          r_mf <= 1'b1;
      else if (w_ctrlWr && i_wdata[CTRL_MF]) r_mf <= 1'b0;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_cmp  = r_cmp;
  assign o_ctrl = {r_mf, r_ie, 2'b00, r_psc, r_en};
  assign o_irq  = r_mf && r_ie;

endmodule

// File: rtl/data_mem.sv
// Data-memory responder for the 8-bit core: general RAM below MMIO_BASE and a
// 16-byte peripheral window (GPIO + timer) above it, with combinational reads.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int                        MEM_ADDR_WIDTH = 8,
  parameter int                        MEM_DATA_WIDTH = 8,
  parameter logic [MEM_ADDR_WIDTH-1:0] MMIO_BASE      = 8'hF0
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_data_i,
  input  logic                      mem_WE,
  output logic [MEM_DATA_WIDTH-1:0] mem_data_o,
  input  logic [7:0]                gpio_i,
  output logic [7:0]                gpio_o,
  output logic                      irq_o
);

  localparam int RAM_DEPTH = int'(MMIO_BASE);

  logic [MEM_DATA_WIDTH-1:0] r_ram [0:RAM_DEPTH-1];
  logic [7:0]                r_gpioOut;
  logic [7:0]                r_sync1;
  logic [7:0]                r_sync2;

  region_e                   w_region;
  logic [MEM_ADDR_WIDTH-1:0] w_offset;
  logic [7:0]                w_periphWdata;
  logic                      w_wrRam;
  logic                      w_wrGpioOut;
  logic [7:0]                w_tmrCnt;
  logic [7:0]                w_tmrCmp;
  logic [7:0]                w_tmrCtrl;

  assign w_offset      = mem_addr - MMIO_BASE;
  assign w_periphWdata = mem_data_i[7:0];

  // Anything above the 16-byte window is unmapped and reads zero.
  always_comb begin
    w_region = RGN_UNMAPPED;
    if (mem_addr < MMIO_BASE)
      w_region = RGN_RAM;
    else if ((w_offset >> PERIPH_OFF_W) == '0)
      w_region = decodeOffset(w_offset[PERIPH_OFF_W-1:0]);
  end

  assign w_wrRam     = mem_WE && (w_region == RGN_RAM);
  assign w_wrGpioOut = mem_WE && (w_region == RGN_GPIO_OUT);

  // Gating on arst_n drops a RAM write that lands while reset is asserted.
  always_ff @(posedge clk) begin
    if (arst_n && w_wrRam)
      r_ram[mem_addr] <= mem_data_i;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_gpioOut <= 8'h00;
      r_sync1   <= 8'h00;
      r_sync2   <= 8'h00;
    end else begin
      if (w_wrGpioOut) r_gpioOut <= w_periphWdata;
      r_sync1 <= gpio_i;
      r_sync2 <= r_sync1;
    end
  end

  mmio_timer u_timer (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_we      (mem_WE),
    .i_selCnt  (w_region == RGN_TMR_CNT),
    .i_selCmp  (w_region == RGN_TMR_CMP),
    .i_selCtrl (w_region == RGN_TMR_CTRL),
    .i_wdata   (w_periphWdata),
    .o_cnt     (w_tmrCnt),
    .o_cmp     (w_tmrCmp),
    .o_ctrl    (w_tmrCtrl),
    .o_irq     (irq_o)
  );

  always_comb begin
    mem_data_o = '0;
    case (w_region)
      RGN_RAM:      mem_data_o = r_ram[mem_addr];
      RGN_GPIO_OUT: mem_data_o = MEM_DATA_WIDTH'(r_gpioOut);
      RGN_GPIO_IN:  mem_data_o = MEM_DATA_WIDTH'(r_sync2);
      RGN_TMR_CNT:  mem_data_o = MEM_DATA_WIDTH'(w_tmrCnt);
      RGN_TMR_CMP:  mem_data_o = MEM_DATA_WIDTH'(w_tmrCmp);
      RGN_TMR_CTRL: mem_data_o = MEM_DATA_WIDTH'(w_tmrCtrl);
      default:      mem_data_o = '0;
    endcase
  end

  assign gpio_o = r_gpioOut;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: vector table, hand-written timer/reset
// sequences, then randomized traffic against a behavioural model.
module tb_data_mem;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_i;
  logic       mem_WE;
  logic [7:0] mem_data_o;
  logic [7:0] gpio_i;
  logic [7:0] gpio_o;
  logic       irq_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem #(
    .MEM_ADDR_WIDTH (8),
    .MEM_DATA_WIDTH (8),
    .MMIO_BASE      (8'hF0)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .mem_addr   (mem_addr),
    .mem_data_i (mem_data_i),
    .mem_WE     (mem_WE),
    .mem_data_o (mem_data_o),
    .gpio_i     (gpio_i),
    .gpio_o     (gpio_o),
    .irq_o      (irq_o)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         we;
    bit         chk;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  // Behavioural model: memory contents as arrays, timer as "cycles since enable".
  logic [7:0] mRam   [0:255];
  bit         mKnown [0:255];
  logic [7:0] mGpo, mCnt, mCmp, mS1, mS2;
  bit         mEn, mIe, mMf;
  int         mPsc, mPhase;

  task automatic modelReset();
    mGpo = 8'h00; mCnt = 8'h00; mCmp = 8'hFF;
    mEn = 1'b0; mIe = 1'b0; mMf = 1'b0;
    mPsc = 0; mPhase = 0;
    mS1 = 8'h00; mS2 = 8'h00;
  endtask

  function automatic int modelRead(input logic [7:0] a);
    logic [7:0] off;
    if (a < 8'hF0) return mKnown[a] ? int'(mRam[a]) : -1;
    off = a - 8'hF0;
    case (off)
      8'd0:    return int'(mGpo);
      8'd1:    return int'(mS2);
      8'd2:    return int'(mCnt);
      8'd3:    return int'(mCmp);
      8'd4:    return int'({mMf, mIe, 2'b00, 3'(mPsc), mEn});
      default: return 0;
    endcase
  endfunction

  task automatic modelEdge(input logic [7:0] a, input logic [7:0] d, input bit we,
                           input logic [7:0] gin);
    int         period;
    bit         tick;
    bit         ctrlWr;
    bit         setMf;
    logic [7:0] nextCnt;
    period  = 1 << mPsc;
    tick    = mEn && ((mPhase % period) == period - 1);
    ctrlWr  = we && (a == 8'hF4);
    setMf   = 1'b0;
    nextCnt = mCnt;
    if (we && a == 8'hF2) nextCnt = d;
    else if (tick) begin
      nextCnt = mCnt + 8'd1;
      setMf   = (nextCnt == mCmp);
    end
    if (setMf) mMf = 1'b1;
    else if (ctrlWr && d[7]) mMf = 1'b0;
    mPhase = (ctrlWr || !mEn) ? 0 : (mPhase + 1) % 256;
    mCnt = nextCnt;
    if (we && a == 8'hF3) mCmp = d;
    if (ctrlWr) begin
      mEn  = d[0];
      mPsc = int'(d[3:1]);
      mIe  = d[6];
    end
    if (we && a == 8'hF0) mGpo = d;
    if (we && a < 8'hF0) begin
      mRam[a]   = d;
      mKnown[a] = 1'b1;
    end
    mS2 = mS1;
    mS1 = gin;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input bit we);
    mem_addr   = a;
    mem_data_i = d;
    mem_WE     = we;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    applyStimulus(a, 8'h00, 1'b0);
    #1;
    checkOutput(name, mem_data_o, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(a, d, 1'b1);
    @(posedge clk);
    #1;
    mem_WE = 1'b0;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic doCycle(input logic [7:0] a, input logic [7:0] d, input bit we);
    int e;
    applyStimulus(a, d, we);
    #1;
    e = modelRead(a);
    if (e >= 0) checkOutput("rand_rdata", mem_data_o, 8'(e));
    checkOutput("rand_gpio_o", gpio_o, mGpo);
    checkOutput("rand_irq", {7'b0, irq_o}, {7'b0, mMf & mIe});
    @(posedge clk);
    modelEdge(a, d, we, gpio_i);
    #1;
  endtask

  logic [7:0] ramAddrs [8];

  initial begin
    vecs[0]  = '{8'h10, 8'h5A, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{8'hEF, 8'hA5, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{8'h10, 8'h00, 1'b0, 1'b1, 8'h5A};
    vecs[3]  = '{8'hEF, 8'h00, 1'b0, 1'b1, 8'hA5};
    vecs[4]  = '{8'hF7, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[5]  = '{8'hF0, 8'h3C, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{8'hF0, 8'h00, 1'b0, 1'b1, 8'h3C};
    vecs[7]  = '{8'hF1, 8'h55, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{8'hF1, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[9]  = '{8'hF9, 8'h12, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{8'hF9, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[11] = '{8'hF5, 8'h00, 1'b0, 1'b1, 8'h00};

    ramAddrs[0] = 8'h10; ramAddrs[1] = 8'hEF; ramAddrs[2] = 8'h00; ramAddrs[3] = 8'h01;
    ramAddrs[4] = 8'h7F; ramAddrs[5] = 8'h80; ramAddrs[6] = 8'hEE; ramAddrs[7] = 8'h42;

    // Reset state
    arst_n = 1'b0;
    gpio_i = 8'h00;
    applyStimulus(8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gpio_o", gpio_o, 8'h00);
    checkOutput("reset_irq", {7'b0, irq_o}, 8'h00);
    rd(8'hF0, 8'h00, "reset_gpio_out");
    rd(8'hF2, 8'h00, "reset_tmr_cnt");
    rd(8'hF3, 8'hFF, "reset_tmr_cmp");
    rd(8'hF4, 8'h00, "reset_tmr_ctrl");
    arst_n = 1'b1;
    clk1();

    // RAM and mapped-register vectors
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].we);
      #1;
      if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), mem_data_o, vecs[i].exp);
      clk1();
    end
    checkOutput("gpio_o_after_write", gpio_o, 8'h3C);

    // Two-flop synchronizer latency
    gpio_i = 8'h81;
    rd(8'hF1, 8'h00, "gpioin_0edge");
    clk1();
    rd(8'hF1, 8'h00, "gpioin_1edge");
    clk1();
    rd(8'hF1, 8'h81, "gpioin_2edge");

    // Timer at PSC=0 with match and interrupt
    wr(8'hF3, 8'h03);
    wr(8'hF4, 8'h41);
    rd(8'hF2, 8'h00, "tmr_c0");
    clk1();
    rd(8'hF2, 8'h01, "tmr_c1");
    clk1();
    rd(8'hF2, 8'h02, "tmr_c2");
    checkOutput("irq_before_match", {7'b0, irq_o}, 8'h00);
    clk1();
    rd(8'hF2, 8'h03, "tmr_c3");
    checkOutput("irq_after_match", {7'b0, irq_o}, 8'h01);
    rd(8'hF4, 8'hC1, "ctrl_mf_set");
    wr(8'hF4, 8'hC1);
    checkOutput("irq_cleared", {7'b0, irq_o}, 8'h00);
    rd(8'hF4, 8'h41, "ctrl_mf_cleared");
    wr(8'hF4, 8'h00);

    // PSC=2 wrap without flag
    wr(8'hF3, 8'h10);
    wr(8'hF2, 8'hFE);
    wr(8'hF4, 8'h05);
    rd(8'hF2, 8'hFE, "wrap_c0");
    repeat (3) clk1();
    rd(8'hF2, 8'hFE, "wrap_c3");
    clk1();
    rd(8'hF2, 8'hFF, "wrap_c4");
    repeat (3) clk1();
    rd(8'hF2, 8'hFF, "wrap_c7");
    clk1();
    rd(8'hF2, 8'h00, "wrap_c8");
    rd(8'hF4, 8'h05, "wrap_no_flag");
    wr(8'hF4, 8'h00);

    // Simultaneous-event priorities
    wr(8'hF2, 8'h00);
    wr(8'hF4, 8'h01);
    wr(8'hF2, 8'h20);
    rd(8'hF2, 8'h20, "cnt_write_wins");
    wr(8'hF3, 8'h22);
    wr(8'hF4, 8'h81);
    rd(8'hF4, 8'h81, "mf_set_wins");
    wr(8'hF4, 8'h81);
    wr(8'hF3, 8'h24);
    rd(8'hF4, 8'h01, "cmp_old_value_used");
    rd(8'hF2, 8'h24, "cnt_after_cmp_write");
    wr(8'hF4, 8'h00);

    // Asynchronous reset mid-count with a pending RAM write
    wr(8'hF2, 8'h30);
    wr(8'hF3, 8'h31);
    wr(8'hF4, 8'h41);
    clk1();
    checkOutput("irq_pre_reset", {7'b0, irq_o}, 8'h01);
    wr(8'hF0, 8'hFF);
    checkOutput("gpio_o_pre_reset", gpio_o, 8'hFF);
    applyStimulus(8'h10, 8'h77, 1'b1);
    #2;
    arst_n = 1'b0;
    #1;
    checkOutput("rst_gpio_o_async", gpio_o, 8'h00);
    checkOutput("rst_irq_async", {7'b0, irq_o}, 8'h00);
    @(posedge clk);
    #1;
    rd(8'hF0, 8'h00, "rst_gpio_out");
    rd(8'hF1, 8'h00, "rst_gpio_in");
    rd(8'hF2, 8'h00, "rst_tmr_cnt");
    rd(8'hF3, 8'hFF, "rst_tmr_cmp");
    rd(8'hF4, 8'h00, "rst_tmr_ctrl");
    arst_n = 1'b1;
    modelReset();
    mRam[8'h10] = 8'h5A; mKnown[8'h10] = 1'b1;
    mRam[8'hEF] = 8'hA5; mKnown[8'hEF] = 1'b1;
    rd(8'h10, 8'h5A, "ram_write_in_reset_dropped");
    doCycle(8'h10, 8'h00, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] a;
      logic [7:0] d;
      bit         we;
      int         r;
      if ($urandom_range(0, 15) == 0) gpio_i = 8'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 5)       a = 8'hF0 + 8'($urandom_range(0, 5));
      else if (r == 5) a = 8'hF0 + 8'($urandom_range(0, 15));
      else             a = ramAddrs[$urandom_range(0, 7)];
      we = ($urandom_range(0, 1) == 1);
      d  = 8'($urandom);
      if (a == 8'hF4) begin
        d = d & 8'hF7;
        if ($urandom_range(0, 3) != 0) d = d | 8'h01;
      end
      if (a == 8'hF3 && $urandom_range(0, 1) == 1) d = mCnt + 8'($urandom_range(1, 4));
      doCycle(a, d, we);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
